enigma_seq_ctrl: RTL and testbench
==================================

# enigma_seq_ctrl

Sequencer for the Enigma encryption datapath. It accepts one letter code per keypress and steps the three rotor position registers it owns. It then drives a single shared substitution unit (rotors 0–2 and the fixed reflector) through the seven Enigma passes and returns the ciphertext letter over a valid/ready handshake. It sits between the keypad decoder and the letter display, and it owns all rotor state.

## Interface
Parameters:
- NOTCH0, 17: rotor-0 position at which rotor 1 is carried.
- NOTCH1, 5: rotor-1 position at which rotor 2 is carried.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  letter code presented.
- key_code  in  5  letter code, 1..26 = A..Z; 0 and 27..31 are invalid.
- key_ready  out  1  controller can accept a key.
- out_valid  out  1  result available.
- out_code  out  5  result letter, 1..26; 0 = invalid.
- out_ready  in  1  consumer takes result.
- pos_load  in  1  load rotor positions.
- pos_load_val0 / pos_load_val1 / pos_load_val2  in  5 each  positions to load.
- pos0 / pos1 / pos2  out  5 each  current rotor positions, 1..26.
- perm_sel  out  3  substitution select (see Operation).
- perm_in  out  5  letter into the substitution unit.
- perm_out  in  5  combinational result from the substitution unit, same cycle.

## Operation
- **States and sequence:** IDLE → STEP → F0 → F1 → F2 → REFL → B2 → B1 → B0 → DONE → IDLE.
- **key_ready:** asserted only in IDLE with pos_load low.
- **Accept:** a key is accepted when key_valid && key_ready. The code is latched into data register d.
- **Invalid code:** an invalid key_code is accepted, but there is no step and no passes; go directly to DONE with out_code = 0.
- **STEP:** rotor 0 always advances.
  - Rotor 1 advances if pos0 == NOTCH0.
  - Rotor 2 advances if pos1 == NOTCH1 and rotor 1 is also advancing.
  - Double-step behaviour is set by the macro in Configuration.
  - All conditions are evaluated on pre-step values. Every increment wraps 26 → 1.
- **perm_sel encoding:** 0 = R0 forward, 1 = R1 forward, 2 = R2 forward, 3 = reflector, 4 = R2 backward, 5 = R1 backward, 6 = R0 backward, 7 = idle. It is 7 in IDLE, STEP and DONE.
- **Rotor pass with position p:**
  - perm_in = add26(d, p−1).
  - At the end of the cycle, d ← sub26(perm_out, p−1).
- **Reflector pass:** perm_in = d; d ← perm_out.
- **Modular arithmetic:**
  - add26(a, k) = a + k, then subtract 26 if the result is > 26.
  - sub26(a, k) = a − k, then add 26 if the result is < 1.
  - Computed 6 bits wide; operands are 1..26 and k is 0..25.
- **Bad substitution result:** if perm_out is 0 or > 26 in any pass, set a sticky error for this letter. Remaining passes still run, and out_code = 0.
- **DONE:** out_valid = 1 and out_code = d. Return to IDLE on out_ready.
- **Position load:** pos_load in IDLE loads all three positions. An out-of-range load value (0, 27..31) is coerced to 1. pos_load outside IDLE is ignored.

## Timing
- **Reset values:**
  - State IDLE; pos0 = pos1 = pos2 = 1; d = 0.
  - key_ready = 1, out_valid = 0, out_code = 0, perm_sel = 7, perm_in = 0.
- **Latency, valid key accepted at cycle N:**
  - STEP at N+1; positions are updated at the end of N+1.
  - Passes run in N+2..N+8.
  - out_valid = 1 from N+9.
- **Latency, invalid key:** out_valid = 1 at N+1.
- **Output hold:** out_valid and out_code stay stable until out_ready. The handshake completes in the cycle where both out_valid and out_ready are high; key_ready rises the next cycle. Throughput is at most one letter per 10 cycles.
- **Load vs. key:** pos_load and key_valid high together in IDLE means the load wins and the key is not accepted. New positions are visible on pos0..pos2 the next cycle.
- **Reset mid-operation:** rst in any state returns to reset values next cycle. A pending result is discarded.

## Configuration
- **ENIGMA_DOUBLE_STEP_EN defined:** historical double step. In STEP, if pos1 == NOTCH1, both rotor 1 and rotor 2 advance, regardless of rotor 0.
- **ENIGMA_DOUBLE_STEP_EN undefined:** pure odometer.
  - Rotor 1 advances only when pos0 == NOTCH0.
  - Rotor 2 advances only when rotor 1 advances while pos1 == NOTCH1.

## Test plan
Default parameters throughout.

- **Basic encrypt:** identity rotor model in bench; load (1,1,1); key 1 → out_code 14 at accept+9, positions (2,1,1). Key 20 → 7.
- **Carry:** load (17,1,1); valid key → positions (18,2,1).
- **Double step:** load (1,5,1); valid key.
  - With ENIGMA_DOUBLE_STEP_EN → (2,6,2).
  - Without → (2,5,1).
- **Wrap:** load (26,26,26); valid key → (1,26,26). Load (17,26,5) with macro off → (18,1,1) with rotor 2 unchanged at 5? No: rotor 1 carries 26 → 1 and rotor 2 stays at 5, giving (18,1,5).
- **Invalid and bad data:**
  - key 0 → out_code 0 at accept+1, positions unchanged.
  - Bench forces perm_out = 0 during REFL → out_code 0.
- **Backpressure and reset:**
  - out_ready held low 5 cycles → out_valid and out_code stable, key_ready = 0.
  - rst asserted during F1 → next cycle IDLE, positions (1,1,1), out_valid 0.

Source files
------------

// File: rtl/enigma_seq_ctrl.sv
// rtl/enigma_seq_ctrl.sv - Enigma keypress sequencer: rotor stepping and seven-pass substitution control.
// Optional feature: define ENIGMA_DOUBLE_STEP_EN for the historical rotor-1 double step.
module enigma_seq_ctrl #(
  parameter int NOTCH0 = 17,
  parameter int NOTCH1 = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  output logic       key_ready,
  output logic       out_valid,
  output logic [4:0] out_code,
  input  logic       out_ready,
  input  logic       pos_load,
  input  logic [4:0] pos_load_val0,
  input  logic [4:0] pos_load_val1,
  input  logic [4:0] pos_load_val2,
  output logic [4:0] pos0,
  output logic [4:0] pos1,
  output logic [4:0] pos2,
  output logic [2:0] perm_sel,
  output logic [4:0] perm_in,
  input  logic [4:0] perm_out
);

  typedef enum logic [3:0] {
    IDLE, STEP, F0, F1, F2, REFL, B2, B1, B0, DONE
  } state_t;

  state_t     state;
  state_t     pass_next;
  logic [4:0] d;
  logic       err;

  function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] k);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, k};
    if (s > 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] k);
    logic [5:0] s;
    if (a > k) s = {1'b0, a} - {1'b0, k};
    else       s = {1'b0, a} + 6'd26 - {1'b0, k};
    return s[4:0];
  endfunction

  function automatic logic [4:0] coerce(input logic [4:0] v);
    return (v == 5'd0 || v > 5'd26) ? 5'd1 : v;
  endfunction

  function automatic logic [4:0] inc26(input logic [4:0] p);
    return (p == 5'd26) ? 5'd1 : p + 5'd1;
  endfunction

  function automatic logic [2:0] sel_of(input state_t s);
    case (s)
      F0:      return 3'd0;
      F1:      return 3'd1;
      F2:      return 3'd2;
      REFL:    return 3'd3;
      B2:      return 3'd4;
      B1:      return 3'd5;
      B0:      return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  // Stepping decisions use pre-step positions.
  logic       adv1, adv2;
  logic [4:0] pos0_nx, pos1_nx, pos2_nx;
  always_comb begin
`ifdef ENIGMA_DOUBLE_STEP_EN
    adv1 = (pos0 == 5'(NOTCH0)) || (pos1 == 5'(NOTCH1));
`else
    adv1 = (pos0 == 5'(NOTCH0));
`endif
    adv2    = adv1 && (pos1 == 5'(NOTCH1));
    pos0_nx = inc26(pos0);
    pos1_nx = adv1 ? inc26(pos1) : pos1;
    pos2_nx = adv2 ? inc26(pos2) : pos2;
  end

  logic [4:0] cur_p, nxt_p, d_pass, perm_in_nx, step_in;
  logic       bad;
  always_comb begin
    case (state)
      F0:      pass_next = F1;
      F1:      pass_next = F2;
      F2:      pass_next = REFL;
      REFL:    pass_next = B2;
      B2:      pass_next = B1;
      B1:      pass_next = B0;
      default: pass_next = DONE;
    endcase
    case (state)
      F1, B1:  cur_p = pos1;
      F2, B2:  cur_p = pos2;
      default: cur_p = pos0;
    endcase
    case (pass_next)
      F1, B1:  nxt_p = pos1;
      F2, B2:  nxt_p = pos2;
      default: nxt_p = pos0;
    endcase
    bad        = (perm_out == 5'd0) || (perm_out > 5'd26);
    d_pass     = (state == REFL) ? perm_out : sub26(perm_out, cur_p - 5'd1);
    perm_in_nx = (pass_next == REFL) ? d_pass : add26(d_pass, nxt_p - 5'd1);
    step_in    = add26(d, pos0_nx - 5'd1);
  end

  assign key_ready = (state == IDLE) && !pos_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pos0      <= 5'd1;
      pos1      <= 5'd1;
      pos2      <= 5'd1;
      d         <= 5'd0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_code  <= 5'd0;
      perm_sel  <= 3'd7;
      perm_in   <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pos_load) begin
            pos0 <= coerce(pos_load_val0);
            pos1 <= coerce(pos_load_val1);
            pos2 <= coerce(pos_load_val2);
          end else if (key_valid) begin
            d   <= key_code;
            err <= 1'b0;
            if (key_code >= 5'd1 && key_code <= 5'd26) begin
              state <= STEP;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_code  <= 5'd0;
            end
          end
        end
        STEP: begin
          pos0     <= pos0_nx;
          pos1     <= pos1_nx;
          pos2     <= pos2_nx;
          state    <= F0;
          perm_sel <= 3'd0;
          perm_in  <= step_in;
        end
        F0, F1, F2, REFL, B2, B1, B0: begin
          d     <= d_pass;
          err   <= err | bad;
          state <= pass_next;
          if (pass_next == DONE) begin
            perm_sel  <= 3'd7;
            perm_in   <= 5'd0;
            out_valid <= 1'b1;
            out_code  <= (err | bad) ? 5'd0 : d_pass;
          end else begin
            perm_sel <= sel_of(pass_next);
            perm_in  <= perm_in_nx;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_code  <= 5'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_seq_ctrl.sv
// tb/tb_enigma_seq_ctrl.sv - directed self-checking bench for enigma_seq_ctrl with identity rotors.
module tb_enigma_seq_ctrl;
  logic       clk = 0;
  logic       rst = 1;
  logic       key_valid = 0;
  logic [4:0] key_code = 0;
  logic       key_ready;
  logic       out_valid;
  logic [4:0] out_code;
  logic       out_ready = 0;
  logic       pos_load = 0;
  logic [4:0] pos_load_val0 = 0, pos_load_val1 = 0, pos_load_val2 = 0;
  logic [4:0] pos0, pos1, pos2;
  logic [2:0] perm_sel;
  logic [4:0] perm_in;
  logic [4:0] perm_out;
  logic       force_bad = 0;

  int n_cmp = 0;
  int n_bad = 0;

  enigma_seq_ctrl dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .out_valid(out_valid), .out_code(out_code),
    .out_ready(out_ready), .pos_load(pos_load), .pos_load_val0(pos_load_val0),
    .pos_load_val1(pos_load_val1), .pos_load_val2(pos_load_val2),
    .pos0(pos0), .pos1(pos1), .pos2(pos2), .perm_sel(perm_sel),
    .perm_in(perm_in), .perm_out(perm_out)
  );

  always #5 clk = ~clk;

  // Identity rotors; reflector shifts by 13 so every letter maps to letter+13.
  always_comb begin
    perm_out = perm_in;
    if (perm_sel == 3'd3) perm_out = force_bad ? 5'd0 : ((perm_in > 5'd13) ? perm_in - 5'd13 : perm_in + 5'd13);
  end

  task automatic load_pos(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    pos_load = 1; pos_load_val0 = a; pos_load_val1 = b; pos_load_val2 = c;
    @(posedge clk); #1;
    pos_load = 0;
  endtask

  task automatic press(input logic [4:0] c);
    key_valid = 1; key_code = c;
    @(posedge clk); #1;
    key_valid = 0; key_code = 0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL reset_key_ready: got %0d want 1", key_ready); end
    n_cmp++; if (out_valid !== 1'b0 || out_code !== 5'd0) begin n_bad++; $display("FAIL reset_out: got valid=%0d code=%0d want 0/0", out_valid, out_code); end
    n_cmp++; if (perm_sel !== 3'd7 || perm_in !== 5'd0) begin n_bad++; $display("FAIL reset_perm: got sel=%0d in=%0d want 7/0", perm_sel, perm_in); end
    n_cmp++; if ({pos0, pos1, pos2} !== {5'd1, 5'd1, 5'd1}) begin n_bad++; $display("FAIL reset_pos: got %0d,%0d,%0d want 1,1,1", pos0, pos1, pos2); end
    rst = 0;
  endtask

  task automatic test_basic;
    int lat;
    load_pos(1, 1, 1);
    press(1);
    wait_valid(lat);
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL basic_latency: got %0d want 9", lat); end
    n_cmp++; if (out_code !== 5'd14) begin n_bad++; $display("FAIL basic_key1: got %0d want 14", out_code); end
    n_cmp++; if ({pos0, pos1, pos2} !== {5'd2, 5'd1, 5'd1}) begin n_bad++; $display("FAIL basic_pos: got %0d,%0d,%0d want 2,1,1", pos0, pos1, pos2); end
    take;
    n_cmp++; if (key_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_handshake: got ready=%0d valid=%0d want 1/0", key_ready, out_valid); end
  endtask

  task automatic test_sequence;
    int lat;
    press(20);
    n_cmp++; if (perm_sel !== 3'd7) begin n_bad++; $display("FAIL seq_step_sel: got %0d want 7", perm_sel); end
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (perm_sel !== 3'(k)) begin n_bad++; $display("FAIL seq_sel%0d: got %0d want %0d", k, perm_sel, k); end
      if (k == 0) begin
        n_cmp++; if (perm_in !== 5'd22) begin n_bad++; $display("FAIL seq_f0_in: got %0d want 22", perm_in); end
      end
    end
    wait_valid(lat);
    n_cmp++; if (out_code !== 5'd7) begin n_bad++; $display("FAIL seq_key20: got %0d want 7", out_code); end
    n_cmp++; if ({pos0, pos1, pos2} !== {5'd3, 5'd1, 5'd1}) begin n_bad++; $display("FAIL seq_pos: got %0d,%0d,%0d want 3,1,1", pos0, pos1, pos2); end
    take;
  endtask

  task automatic test_carry;
    int lat;
    load_pos(17, 1, 1);
    press(5);
    wait_valid(lat);
    n_cmp++; if ({pos0, pos1, pos2} !== {5'd18, 5'd2, 5'd1}) begin n_bad++; $display("FAIL carry_pos: got %0d,%0d,%0d want 18,2,1", pos0, pos1, pos2); end
    n_cmp++; if (out_code !== 5'd18) begin n_bad++; $display("FAIL carry_code: got %0d want 18", out_code); end
    take;
  endtask

  task automatic test_double_step;
    int lat;
    logic [14:0] want;
`ifdef ENIGMA_DOUBLE_STEP_EN
    want = {5'd2, 5'd6, 5'd2};
`else
    want = {5'd2, 5'd5, 5'd1};
`endif
    load_pos(1, 5, 1);
    press(3);
    wait_valid(lat);
    n_cmp++; if ({pos0, pos1, pos2} !== want) begin n_bad++; $display("FAIL double_step_pos: got %0d,%0d,%0d want %0d,%0d,%0d", pos0, pos1, pos2, want[14:10], want[9:5], want[4:0]); end
    take;
  endtask

  task automatic test_wrap;
    int lat;
    load_pos(26, 26, 26);
    press(26);
    wait_valid(lat);
    n_cmp++; if ({pos0, pos1, pos2} !== {5'd1, 5'd26, 5'd26}) begin n_bad++; $display("FAIL wrap_pos: got %0d,%0d,%0d want 1,26,26", pos0, pos1, pos2); end
    n_cmp++; if (out_code !== 5'd13) begin n_bad++; $display("FAIL wrap_code: got %0d want 13", out_code); end
    take;
`ifndef ENIGMA_DOUBLE_STEP_EN
    load_pos(17, 26, 5);
    press(2);
    wait_valid(lat);
    n_cmp++; if ({pos0, pos1, pos2} !== {5'd18, 5'd1, 5'd5}) begin n_bad++; $display("FAIL wrap_carry_pos: got %0d,%0d,%0d want 18,1,5", pos0, pos1, pos2); end
    take;
`endif
  endtask

  task automatic test_load;
    load_pos(0, 27, 31);
    n_cmp++; if ({pos0, pos1, pos2} !== {5'd1, 5'd1, 5'd1}) begin n_bad++; $display("FAIL load_coerce: got %0d,%0d,%0d want 1,1,1", pos0, pos1, pos2); end
    pos_load = 1; pos_load_val0 = 7; pos_load_val1 = 8; pos_load_val2 = 9;
    key_valid = 1; key_code = 3;
    #1;
    n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL load_blocks_ready: got %0d want 0", key_ready); end
    @(posedge clk); #1;
    pos_load = 0; key_valid = 0; key_code = 0;
    n_cmp++; if ({pos0, pos1, pos2} !== {5'd7, 5'd8, 5'd9}) begin n_bad++; $display("FAIL load_wins_pos: got %0d,%0d,%0d want 7,8,9", pos0, pos1, pos2); end
    @(posedge clk); #1;
    n_cmp++; if (key_ready !== 1'b1 || perm_sel !== 3'd7 || out_valid !== 1'b0) begin n_bad++; $display("FAIL load_wins_idle: got ready=%0d sel=%0d valid=%0d want 1/7/0", key_ready, perm_sel, out_valid); end
  endtask

  task automatic test_invalid;
    int lat;
    press(0);
    wait_valid(lat);
    n_cmp++; if (lat !== 1 || out_code !== 5'd0) begin n_bad++; $display("FAIL invalid0: got lat=%0d code=%0d want 1/0", lat, out_code); end
    n_cmp++; if ({pos0, pos1, pos2} !== {5'd7, 5'd8, 5'd9}) begin n_bad++; $display("FAIL invalid_pos: got %0d,%0d,%0d want 7,8,9", pos0, pos1, pos2); end
    take;
    press(27);
    wait_valid(lat);
    n_cmp++; if (lat !== 1 || out_code !== 5'd0) begin n_bad++; $display("FAIL invalid27: got lat=%0d code=%0d want 1/0", lat, out_code); end
    take;
    force_bad = 1;
    press(4);
    wait_valid(lat);
    force_bad = 0;
    n_cmp++; if (lat !== 9 || out_code !== 5'd0) begin n_bad++; $display("FAIL bad_refl: got lat=%0d code=%0d want 9/0", lat, out_code); end
    take;
    press(4);
    wait_valid(lat);
    n_cmp++; if (out_code !== 5'd17) begin n_bad++; $display("FAIL err_cleared: got %0d want 17", out_code); end
    take;
  endtask

  task automatic test_backpressure;
    int lat;
    press(10);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || out_code !== 5'd23 || key_ready !== 1'b0) begin n_bad++; $display("FAIL hold%0d: got valid=%0d code=%0d ready=%0d want 1/23/0", i, out_valid, out_code, key_ready); end
    end
    take;
  endtask

  task automatic test_reset_mid;
    load_pos(3, 4, 5);
    press(9);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (perm_sel !== 3'd1) begin n_bad++; $display("FAIL mid_in_f1: got %0d want 1", perm_sel); end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    n_cmp++; if ({pos0, pos1, pos2} !== {5'd1, 5'd1, 5'd1}) begin n_bad++; $display("FAIL mid_reset_pos: got %0d,%0d,%0d want 1,1,1", pos0, pos1, pos2); end
    n_cmp++; if (out_valid !== 1'b0 || key_ready !== 1'b1 || perm_sel !== 3'd7) begin n_bad++; $display("FAIL mid_reset_state: got valid=%0d ready=%0d sel=%0d want 0/1/7", out_valid, key_ready, perm_sel); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_sequence;
    test_carry;
    test_double_step;
    test_wrap;
    test_load;
    test_invalid;
    test_backpressure;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
